// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter: two cascaded line buffers feed a 3x3 window, followed by a
// three-stage median network (row sort, column reduce, final median). Only interior pixels are
// emitted. A single enable stalls the whole core when the output is held.
module median3x3_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColMax = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowMax = RW'(IMG_H - 1);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t min2(input pix_t x, input pix_t y);
    return (x < y) ? x : y;
  endfunction

  function automatic pix_t max2(input pix_t x, input pix_t y);
    return (x > y) ? x : y;
  endfunction

  function automatic pix_t med3(input pix_t x, input pix_t y, input pix_t z);
    return max2(min2(x, y), min2(max2(x, y), z));
  endfunction

  logic en, acc;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;

  // Position of the pixel being accepted; in_sof resynchronises to (0,0).
  logic [CW-1:0] col_q, pos_col;
  logic [RW-1:0] row_q, pos_row;
  assign pos_col = in_sof ? '0 : col_q;
  assign pos_row = in_sof ? '0 : row_q;

  // Next expected position, wrapping at the end of line and frame.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (acc) begin
      if (pos_col == ColMax) begin
        col_q <= '0;
        row_q <= (pos_row == RowMax) ? '0 : pos_row + RW'(1);
      end else begin
        col_q <= pos_col + CW'(1);
        row_q <= pos_row;
      end
    end
  end

  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];
  pix_t lb0_rd, lb1_rd;
  assign lb0_rd = lb0[pos_col];
  assign lb1_rd = lb1[pos_col];

  // Cascaded line buffers: lb0 holds the previous row, lb1 the one before. Never reset.
  always_ff @(posedge clk_clk) begin
    if (acc) begin
      lb0[pos_col] <= in_data;
      lb1[pos_col] <= lb0_rd;
    end
  end

  // win[r][k]: r=0 oldest row, k=2 newest column.
  pix_t win [3][3];
  logic win_valid_q, win_sof_q;

  // Window shift on accept; window-valid marks a full interior window.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          win[i][k] <= '0;
        end
      end
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
    end else if (en) begin
      if (acc) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= in_data;
      end
      win_valid_q <= acc && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
      win_sof_q   <= acc && (pos_row == RW'(2)) && (pos_col == CW'(2));
    end
  end

  pix_t lo1 [3];
  pix_t mid1 [3];
  pix_t hi1 [3];
  logic v1_q, s1_q;
  pix_t a2_q, b2_q, c2_q;
  logic v2_q, s2_q;

  // Median network: S1 sorts rows, S2 reduces columns, S3 takes the final median.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < 3; i++) begin
        lo1[i]  <= '0;
        mid1[i] <= '0;
        hi1[i]  <= '0;
      end
      v1_q      <= 1'b0;
      s1_q      <= 1'b0;
      a2_q      <= '0;
      b2_q      <= '0;
      c2_q      <= '0;
      v2_q      <= 1'b0;
      s2_q      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        lo1[i]  <= min2(min2(win[i][0], win[i][1]), win[i][2]);
        mid1[i] <= med3(win[i][0], win[i][1], win[i][2]);
        hi1[i]  <= max2(max2(win[i][0], win[i][1]), win[i][2]);
      end
      v1_q      <= win_valid_q;
      s1_q      <= win_sof_q;
      a2_q      <= max2(max2(lo1[0], lo1[1]), lo1[2]);
      b2_q      <= med3(mid1[0], mid1[1], mid1[2]);
      c2_q      <= min2(min2(hi1[0], hi1[1]), hi1[2]);
      v2_q      <= v1_q;
      s2_q      <= s1_q;
      out_data  <= med3(a2_q, b2_q, c2_q);
      out_valid <= v2_q;
      out_sof   <= s2_q;
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
// Bench for median3x3_stream on a 4x4 image: a frame-level model computes each interior
// median by sorting the nine window pixels; directed frames pin the model with literals.
module tb_median3x3_stream;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_valid;
  logic       out_ready = 1'b1;

  median3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame image, expected position, expected output stream.
  int   img [H][W];
  int   mrow = 0, mcol = 0;
  int   exp_q[$];
  bit   exp_sof_q[$];
  int   got[$];
  bit   got_sof[$];
  logic [7:0] frm [16];

  function automatic int med9(input int r, input int c);
    int v[9];
    int t;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++)
        v[i*3+k] = img[r-2+i][c-2+k];
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < 8 - i; k++)
        if (v[k] > v[k+1]) begin
          t = v[k]; v[k] = v[k+1]; v[k+1] = t;
        end
    return v[4];
  endfunction

  int cyc = 0;
  always @(posedge clk_clk) cyc++;

  bit   lat_check = 0, lat_armed = 0;
  int   lat_k = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_sof;
  bit   bp = 0;

  // Random output backpressure: ready about 30% of cycles while bp is set.
  always @(posedge clk_clk) begin
    #1;
    if (bp) out_ready = ($urandom_range(0, 99) < 30);
  end

  // Single compare process, sampling on the falling edge.
  always @(negedge clk_clk) begin
    if (reset_reset) begin
      exp_q.delete();
      exp_sof_q.delete();
      mrow = 0;
      mcol = 0;
      prev_stall = 0;
      lat_armed = 0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_sof", out_sof, prev_sof);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sof   = out_sof;
      if (out_valid && lat_armed) begin
        chk("latency", cyc - lat_k, 3);
        lat_armed = 0;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_sof.push_back(out_sof);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output: got data %0d, expected no output", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_sof", out_sof, exp_sof_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin
          mrow = 0;
          mcol = 0;
        end
        img[mrow][mcol] = in_data;
        if (mrow >= 2 && mcol >= 2) begin
          exp_q.push_back(med9(mrow, mcol));
          exp_sof_q.push_back(mrow == 2 && mcol == 2);
          if (mrow == 2 && mcol == 2 && lat_check) begin
            lat_armed = 1;
            lat_k = cyc + 1;
          end
        end
        mcol++;
        if (mcol == W) begin
          mcol = 0;
          mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit s);
    bit ok;
    in_data  = d;
    in_sof   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_clk);
      ok = in_ready;
      @(posedge clk_clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        return;
      end
    end
    $display("FAIL send_timeout: in_ready stayed low, expected an accept");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "send timeout");
  endtask

  task automatic send_frame(input bit s);
    for (int i = 0; i < 16; i++) send(frm[i], s && (i == 0));
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
    idle(4);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Assert reset between edges, check outputs clear at once, release mid-cycle.
  task automatic async_reset();
    #2;
    reset_reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk_clk);
    @(posedge clk_clk);
    #3;
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    logic [7:0] lit [4];
    repeat (3) @(posedge clk_clk);
    #3;
    reset_reset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sof", out_sof, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk_clk);
    #1;

    // Constant frame, with first-output latency check.
    got.delete(); got_sof.delete();
    for (int i = 0; i < 16; i++) frm[i] = 8'h40;
    lat_check = 1;
    send_frame(1);
    drain();
    lat_check = 0;
    chk("const_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("const_data", got[i], 8'h40);
      chk("const_sof", got_sof[i], i == 0);
    end

    // Ramp rows: hand-computed medians 5,3,5,0.
    got.delete(); got_sof.delete();
    frm = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd4, 8'd5, 8'd6, 8'd0,
            8'd7, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(1);
    drain();
    lit = '{8'd5, 8'd3, 8'd5, 8'd0};
    chk("ramp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("ramp_data", got[i], lit[i]);

    // Impulse removal.
    got.delete(); got_sof.delete();
    for (int i = 0; i < 16; i++) frm[i] = 8'h10;
    frm[5] = 8'hFF;
    send_frame(1);
    drain();
    chk("impulse_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("impulse_data", got[i], 8'h10);

    // Three random frames under random backpressure and input gaps.
    got.delete(); got_sof.delete();
    bp = 1;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      for (int i = 0; i < 16; i++) begin
        send(frm[i], i == 0);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    drain();
    bp = 0;
    out_ready = 1'b1;
    idle(1);
    chk("bp_count", got.size(), 12);

    // Reset while an output is held valid by a stall.
    rand_frame();
    for (int i = 0; i < 11; i++) send(frm[i], i == 0);
    out_ready = 1'b0;
    idle(5);
    chk("stall_valid", out_valid, 1);
    async_reset();
    out_ready = 1'b1;

    // Reset after 10 pixels, then a frame without in_sof.
    rand_frame();
    for (int i = 0; i < 10; i++) send(frm[i], i == 0);
    async_reset();
    got.delete(); got_sof.delete();
    rand_frame();
    send_frame(0);
    drain();
    chk("post_reset_count", got.size(), 4);
    chk("post_reset_sof", got_sof[0], 1);

    // Resync: partial frame, then a fresh frame marked by in_sof.
    rand_frame();
    for (int i = 0; i < 6; i++) send(frm[i], 0);
    got.delete(); got_sof.delete();
    rand_frame();
    send_frame(1);
    drain();
    chk("resync_count", got.size(), 4);

    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
